// File: rtl/register_scoreboard.sv
// Register scoreboard: tracks issued-but-uncommitted writes per architectural
// register and blocks issue on RAW hazards or when a register's pending-write
// counter is full. Register 0 is hard-wired idle.
module register_scoreboard #(
  parameter int REG_NUM    = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 2,
  parameter int WB_BYPASS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issueValid,
  input  logic [ADDR_WIDTH-1:0] rs1Addr,
  input  logic                  rs1Use,
  input  logic [ADDR_WIDTH-1:0] rs2Addr,
  input  logic                  rs2Use,
  input  logic                  rdWriteEnable,
  input  logic [ADDR_WIDTH-1:0] rdAddr,
  input  logic                  wbValid,
  input  logic [ADDR_WIDTH-1:0] wbAddr,
  input  logic                  flush,
  output logic                  stall,
  output logic                  issueAccept,
  output logic [REG_NUM-1:0]    busyVec
);

  // Pending-write counter per register
  logic [CNT_WIDTH-1:0] r_cnt [REG_NUM];

  logic [REG_NUM-1:0]   w_inc;
  logic [REG_NUM-1:0]   w_dec;
  logic [CNT_WIDTH-1:0] w_rs1_cnt;
  logic [CNT_WIDTH-1:0] w_rs2_cnt;
  logic [CNT_WIDTH-1:0] w_rd_cnt;
  logic                 w_bypass1;
  logic                 w_bypass2;
  logic                 w_rs1_haz;
  logic                 w_rs2_haz;
  logic                 w_rd_sat;
  logic                 w_stall;
  logic                 w_accept;

  assign w_rs1_cnt = r_cnt[rs1Addr];
  assign w_rs2_cnt = r_cnt[rs2Addr];
  assign w_rd_cnt  = r_cnt[rdAddr];

  // A same-cycle writeback to a source retires one pending write, so with
  // bypass the source is only hazardous if more than one write is pending.
  assign w_bypass1 = (WB_BYPASS != 0) && wbValid && (wbAddr == rs1Addr);
  assign w_bypass2 = (WB_BYPASS != 0) && wbValid && (wbAddr == rs2Addr);

  assign w_rs1_haz = rs1Use && (rs1Addr != '0) &&
                     (w_bypass1 ? (w_rs1_cnt > CNT_WIDTH'(1)) : (w_rs1_cnt != '0));
  assign w_rs2_haz = rs2Use && (rs2Addr != '0) &&
                     (w_bypass2 ? (w_rs2_cnt > CNT_WIDTH'(1)) : (w_rs2_cnt != '0));

  // Destination saturation uses the stored count only: the counter must never
  // be asked to increment past all-ones, even if a writeback frees a slot.
  assign w_rd_sat = rdWriteEnable && (rdAddr != '0) && (&w_rd_cnt);

  assign w_stall     = issueValid && (w_rs1_haz || w_rs2_haz || w_rd_sat) && !flush;
  assign w_accept    = issueValid && !w_stall && !flush;
  assign stall       = w_stall;
  assign issueAccept = w_accept;

  // Per-register increment/decrement requests and busy flags; register 0 never moves
  generate
    for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_reg
      assign w_inc[gi]   = (gi != 0) && w_accept && rdWriteEnable &&
                           (rdAddr == ADDR_WIDTH'(gi));
      assign w_dec[gi]   = (gi != 0) && wbValid && (wbAddr == ADDR_WIDTH'(gi));
      assign busyVec[gi] = (r_cnt[gi] != '0);
    end
  endgenerate

  // Counter update: reset/flush clear all; issue+writeback to the same register
  // cancel; a writeback with nothing pending leaves the counter at zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < REG_NUM; i++) begin
      if (rst || flush) begin
        r_cnt[i] <= '0;
      end else if (w_inc[i] && !w_dec[i]) begin
        r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
      end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
        r_cnt[i] <= r_cnt[i] - CNT_WIDTH'(1);
      end
    end
  end

endmodule
